// File: rtl/cw305_axil_responder_if.sv
// AXI4-Lite bus bundle between the CW305 crypto-clock initiator and the
// cw305_axil_responder word memory. Signal names follow the responder's
// s_* port list; master drives requests, slave drives responses.
interface cw305_axil_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  s_awvalid;
    logic                  s_awready;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [2:0]            s_awprot;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [1:0]            s_bresp;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [2:0]            s_arprot;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb,
               s_bready, s_arvalid, s_araddr, s_arprot, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp,
               s_arready, s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb,
               s_bready, s_arvalid, s_araddr, s_arprot, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp,
               s_arready, s_rvalid, s_rdata, s_rresp
    );
endinterface

// File: rtl/cw305_axil_responder.sv
// AXI4-Lite responder with a 2**DEPTH_LOG2 x 32-bit word memory, the far end
// of the CW305 crypto-clock initiator (program/data store, result mailbox).
// One outstanding transaction per direction; read and write run independently.
// All valid/ready outputs are registered.
//
// Build option: CW305_AXIL_SLVERR_EN
//   defined   - addresses with any bit >= DEPTH_LOG2+2 set get SLVERR; writes
//               are dropped and reads return zero.
//   undefined - upper address bits are ignored (aliasing), always OKAY.
//
// Write FSM
//   state     | meaning
//   W_COLLECT | gathering AW and W (either order); commit when both present
//   W_RESP    | B response pending, AW/W not ready until B handshake
// Read FSM
//   state     | meaning
//   R_IDLE    | AR ready, waiting for a read address
//   R_RESP    | R data registered and held until R handshake
module cw305_axil_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic resetn,
    cw305_axil_responder_if.slave s_axil
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic { W_COLLECT, W_RESP } w_state_t;
    typedef enum logic { R_IDLE,    R_RESP } r_state_t;

    logic [31:0] r_mem [DEPTH];

    // write channel state and registered outputs
    w_state_t              r_w_state,  w_w_state_nxt;
    logic                  r_aw_held,  w_aw_held_nxt;
    logic                  r_w_held,   w_w_held_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr,   w_awaddr_nxt;
    logic [31:0]           r_wdata,    w_wdata_nxt;
    logic [3:0]            r_wstrb,    w_wstrb_nxt;
    logic                  r_awready,  w_awready_nxt;
    logic                  r_wready,   w_wready_nxt;
    logic                  r_bvalid,   w_bvalid_nxt;
    logic [1:0]            r_bresp,    w_bresp_nxt;

    // read channel state and registered outputs
    r_state_t              r_r_state,  w_r_state_nxt;
    logic                  r_arready,  w_arready_nxt;
    logic                  r_rvalid,   w_rvalid_nxt;
    logic [31:0]           r_rdata,    w_rdata_nxt;
    logic [1:0]            r_rresp,    w_rresp_nxt;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_mem_we;
    logic                  w_aw_oor;
    logic                  w_ar_oor;
    logic [ADDR_WIDTH-1:0] w_awaddr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [DEPTH_LOG2-1:0] w_aw_idx;
    logic [DEPTH_LOG2-1:0] w_ar_idx;

    assign w_aw_hs  = s_axil.s_awvalid & r_awready;
    assign w_w_hs   = s_axil.s_wvalid  & r_wready;
    assign w_ar_hs  = s_axil.s_arvalid & r_arready;

    // A held channel wins over the live bus value; otherwise the handshake
    // happening on this edge supplies it.
    assign w_awaddr = r_aw_held ? r_awaddr : s_axil.s_awaddr;
    assign w_wdata  = r_w_held  ? r_wdata  : s_axil.s_wdata;
    assign w_wstrb  = r_w_held  ? r_wstrb  : s_axil.s_wstrb;

    assign w_aw_idx = w_awaddr[DEPTH_LOG2+1:2];
    assign w_ar_idx = s_axil.s_araddr[DEPTH_LOG2+1:2];

    assign w_commit = (r_w_state == W_COLLECT)
                    & (r_aw_held | w_aw_hs)
                    & (r_w_held  | w_w_hs);
    assign w_mem_we = w_commit & ~w_aw_oor;

`ifdef CW305_AXIL_SLVERR_EN
    assign w_aw_oor = |w_awaddr[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign w_ar_oor = |s_axil.s_araddr[ADDR_WIDTH-1:DEPTH_LOG2+2];

    logic w_unused;
    assign w_unused = ^{s_axil.s_awprot, s_axil.s_arprot,
                        w_awaddr[1:0], s_axil.s_araddr[1:0]};
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;

    logic w_unused;
    assign w_unused = ^{s_axil.s_awprot, s_axil.s_arprot,
                        w_awaddr[1:0], s_axil.s_araddr[1:0],
                        w_awaddr[ADDR_WIDTH-1:DEPTH_LOG2+2],
                        s_axil.s_araddr[ADDR_WIDTH-1:DEPTH_LOG2+2]};
`endif

    // write FSM: next state, capture flags and registered outputs
    always_comb begin
        w_w_state_nxt = r_w_state;
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        case (r_w_state)
            W_COLLECT: begin
                if (w_commit) begin
                    w_w_state_nxt = W_RESP;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_bresp_nxt   = w_aw_oor ? 2'b10 : 2'b00;
                end else begin
                    if (w_aw_hs) begin
                        w_aw_held_nxt = 1'b1;
                        w_awaddr_nxt  = s_axil.s_awaddr;
                    end
                    if (w_w_hs) begin
                        w_w_held_nxt = 1'b1;
                        w_wdata_nxt  = s_axil.s_wdata;
                        w_wstrb_nxt  = s_axil.s_wstrb;
                    end
                    // also raises ready on the first edge after reset
                    w_awready_nxt = ~(r_aw_held | w_aw_hs);
                    w_wready_nxt  = ~(r_w_held  | w_w_hs);
                end
            end
            W_RESP: begin
                if (s_axil.s_bready) begin
                    w_w_state_nxt = W_COLLECT;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: w_w_state_nxt = W_COLLECT;
        endcase
    end

    // write FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_w_state <= W_COLLECT;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    // memory write with byte-lane merge; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb[b]) begin
                    r_mem[w_aw_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // read FSM: next state and registered R channel; memory is sampled
    // before this edge's write lands, so a colliding read sees old data
    always_comb begin
        w_r_state_nxt = r_r_state;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_r_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_r_state_nxt = R_RESP;
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rdata_nxt   = w_ar_oor ? 32'h0 : r_mem[w_ar_idx];
                    w_rresp_nxt   = w_ar_oor ? 2'b10 : 2'b00;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axil.s_rready) begin
                    w_r_state_nxt = R_IDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    // read FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0;
            r_rresp   <= 2'b00;
        end else begin
            r_r_state <= w_r_state_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    assign s_axil.s_awready = r_awready;
    assign s_axil.s_wready  = r_wready;
    assign s_axil.s_bvalid  = r_bvalid;
    assign s_axil.s_bresp   = r_bresp;
    assign s_axil.s_arready = r_arready;
    assign s_axil.s_rvalid  = r_rvalid;
    assign s_axil.s_rdata   = r_rdata;
    assign s_axil.s_rresp   = r_rresp;

endmodule

// File: tb/tb_cw305_axil_responder.sv
// Self-checking bench for cw305_axil_responder: reset values, a table of
// write/readback vectors, hand-written multi-cycle corner cases, and a
// randomized phase checked against a word-array reference model.
// Build with +define+CW305_AXIL_SLVERR_EN to exercise the SLVERR option.
module tb_cw305_axil_responder;
    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cw305_axil_responder_if #(.ADDR_WIDTH(32)) axil ();

    cw305_axil_responder #(.DEPTH_LOG2(8), .ADDR_WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .s_axil (axil.slave)
    );

    // reference model: 256 words plus "fully known" flags
    logic [31:0] m_mem   [256];
    bit          m_known [256];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    function automatic bit model_oor(input logic [31:0] a);
`ifdef CW305_AXIL_SLVERR_EN
        return a >= 32'h400;
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        int idx;
        if (model_oor(a)) begin
            resp = 2'b10;
        end else begin
            idx = int'((a / 4) % 256);
            for (int i = 0; i < 4; i++)
                if (s[i]) m_mem[idx][8*i +: 8] = d[8*i +: 8];
            if (s == 4'hF) m_known[idx] = 1'b1;
            resp = 2'b00;
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d,
                              output logic [1:0] resp, output bit known);
        int idx;
        if (model_oor(a)) begin
            d = 32'h0; resp = 2'b10; known = 1'b1;
        end else begin
            idx = int'((a / 4) % 256);
            d = m_mem[idx]; resp = 2'b00; known = m_known[idx];
        end
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int awd, input int wd,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int n = 0;
        axil.s_awaddr = a; axil.s_wdata = d; axil.s_wstrb = s;
        while (!(aw_done && w_done) && n < 30) begin
            if (!aw_done && n >= awd) axil.s_awvalid = 1'b1;
            if (!w_done  && n >= wd)  axil.s_wvalid  = 1'b1;
            aw_go = axil.s_awvalid && axil.s_awready;
            w_go  = axil.s_wvalid  && axil.s_wready;
            tick();
            if (aw_go) begin axil.s_awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin axil.s_wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        axil.s_awvalid = 1'b0; axil.s_wvalid = 1'b0;
        check("wr_handshake", {aw_done, w_done}, 2'b11);
        check("wr_b_latency", axil.s_bvalid, 1'b1);
        resp = axil.s_bresp;
        axil.s_bready = 1'b1;
        tick();
        axil.s_bready = 1'b0;
        check("wr_b_release", {axil.s_bvalid, axil.s_awready, axil.s_wready}, 3'b011);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        bit done = 0, go;
        int n = 0;
        axil.s_araddr = a; axil.s_arvalid = 1'b1;
        while (!done && n < 30) begin
            go = axil.s_arvalid && axil.s_arready;
            tick();
            if (go) done = 1;
            n++;
        end
        axil.s_arvalid = 1'b0;
        check("rd_handshake", done, 1'b1);
        check("rd_latency", axil.s_rvalid, 1'b1);
        d = axil.s_rdata; resp = axil.s_rresp;
        axil.s_rready = 1'b1;
        tick();
        axil.s_rready = 1'b0;
        check("rd_release", {axil.s_rvalid, axil.s_arready}, 2'b01);
    endtask

    initial begin
        logic [31:0] rd, ed, a, d;
        logic [1:0]  rr, er, br;
        logic [3:0]  s;
        bit          kn;

        vecs[0] = '{32'h10,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{32'h0,   32'hAABBCCDD, 4'hF, 32'hAABBCCDD};
        vecs[2] = '{32'h0,   32'h11223344, 4'h5, 32'hAA22CC44};
        vecs[3] = '{32'h3,   32'hFFFFFFFF, 4'h0, 32'hAA22CC44};
        vecs[4] = '{32'h20,  32'h00000000, 4'hF, 32'h00000000};
        vecs[5] = '{32'h22,  32'hCAFEF00D, 4'hA, 32'hCA00F000};
        vecs[6] = '{32'h3FC, 32'h55AA55AA, 4'hF, 32'h55AA55AA};
        for (int i = 0; i < 256; i++) begin m_mem[i] = 32'h0; m_known[i] = 1'b0; end

        resetn = 1'b0;
        axil.s_awvalid = 0; axil.s_awaddr = 0; axil.s_awprot = 0;
        axil.s_wvalid = 0;  axil.s_wdata = 0;  axil.s_wstrb = 0;
        axil.s_bready = 0;  axil.s_arvalid = 0; axil.s_araddr = 0;
        axil.s_arprot = 0;  axil.s_rready = 0;

        // reset values
        repeat (3) tick();
        check("reset_state", {axil.s_awready, axil.s_wready, axil.s_arready,
              axil.s_bvalid, axil.s_rvalid, axil.s_bresp, axil.s_rresp, axil.s_rdata}, 64'h0);
        @(negedge clk); resetn = 1'b1;
        tick();
        check("ready_after_reset", {axil.s_awready, axil.s_wready, axil.s_arready}, 3'b111);

        // table-driven write/readback
        foreach (vecs[i]) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, br);
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, er);
            check("vec_bresp", br, er);
            axi_read(vecs[i].addr, rd, rr);
            check("vec_rdata", rd, vecs[i].exp);
            check("vec_rresp", rr, 2'b00);
        end

        // W before AW
        axil.s_wdata = 32'h12345678; axil.s_wstrb = 4'hF; axil.s_wvalid = 1'b1;
        tick(); axil.s_wvalid = 1'b0;
        check("wfirst_c1", {axil.s_wready, axil.s_awready, axil.s_bvalid}, 3'b010);
        tick();
        check("wfirst_c2", {axil.s_wready, axil.s_bvalid}, 2'b00);
        tick();
        check("wfirst_c3", {axil.s_wready, axil.s_bvalid}, 2'b00);
        axil.s_awaddr = 32'h4; axil.s_awvalid = 1'b1;
        tick(); axil.s_awvalid = 1'b0;
        check("wfirst_b", {axil.s_bvalid, axil.s_bresp, axil.s_awready, axil.s_wready}, 5'b10000);
        axil.s_bready = 1'b1; tick(); axil.s_bready = 1'b0;
        check("wfirst_release", {axil.s_bvalid, axil.s_awready, axil.s_wready}, 3'b011);
        model_write(32'h4, 32'h12345678, 4'hF, er);
        axi_read(32'h4, rd, rr);
        check("wfirst_readback", rd, 32'h12345678);

        // backpressure on both responses
        axil.s_awaddr = 32'h30; axil.s_wdata = 32'h0BADF00D; axil.s_wstrb = 4'hF;
        axil.s_araddr = 32'h10;
        axil.s_awvalid = 1; axil.s_wvalid = 1; axil.s_arvalid = 1;
        tick();
        axil.s_awvalid = 0; axil.s_wvalid = 0; axil.s_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check("backpressure_hold", {axil.s_bvalid, axil.s_bresp, axil.s_rvalid,
                  axil.s_rresp, axil.s_rdata, axil.s_awready, axil.s_wready, axil.s_arready},
                  {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF, 3'b000});
            tick();
        end
        axil.s_bready = 1; axil.s_rready = 1;
        tick();
        axil.s_bready = 0; axil.s_rready = 0;
        check("backpressure_release", {axil.s_bvalid, axil.s_rvalid, axil.s_awready,
              axil.s_wready, axil.s_arready}, 5'b00111);
        model_write(32'h30, 32'h0BADF00D, 4'hF, er);
        axi_read(32'h30, rd, rr);
        check("backpressure_readback", rd, 32'h0BADF00D);

        // same-edge read and write of one word
        axi_write(32'h8, 32'h1, 4'hF, 0, 0, br);
        model_write(32'h8, 32'h1, 4'hF, er);
        axil.s_awaddr = 32'h8; axil.s_wdata = 32'h2; axil.s_araddr = 32'h8;
        axil.s_awvalid = 1; axil.s_wvalid = 1; axil.s_arvalid = 1;
        axil.s_bready = 1; axil.s_rready = 1;
        tick();
        axil.s_awvalid = 0; axil.s_wvalid = 0; axil.s_arvalid = 0;
        check("collision_old", {axil.s_rvalid, axil.s_bvalid, axil.s_rdata}, {2'b11, 32'h1});
        tick();
        axil.s_bready = 0; axil.s_rready = 0;
        model_write(32'h8, 32'h2, 4'hF, er);
        axi_read(32'h8, rd, rr);
        check("collision_new", rd, 32'h2);

        // out-of-range address
        axi_write(32'h400, 32'h77777777, 4'hF, 0, 0, br);
        model_write(32'h400, 32'h77777777, 4'hF, er);
        check("oor_bresp", br, er);
        model_read(32'h0, ed, er, kn);
        axi_read(32'h0, rd, rr);
        check("oor_word0", {rr, rd}, {er, ed});
        model_read(32'h400, ed, er, kn);
        axi_read(32'h400, rd, rr);
        check("oor_read", {rr, rd}, {er, ed});

        // reset pulsed while the B response is pending
        axil.s_awaddr = 32'h40; axil.s_wdata = 32'h5A5A0001; axil.s_wstrb = 4'hF;
        axil.s_awvalid = 1; axil.s_wvalid = 1;
        tick();
        axil.s_awvalid = 0; axil.s_wvalid = 0;
        check("rst_pending_b", axil.s_bvalid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_drop", {axil.s_bvalid, axil.s_awready, axil.s_wready,
              axil.s_arready, axil.s_rvalid}, 5'b00000);
        @(negedge clk); resetn = 1'b1;
        tick();
        check("rst_recover", {axil.s_bvalid, axil.s_awready, axil.s_wready, axil.s_arready}, 4'b0111);
        model_write(32'h40, 32'h5A5A0001, 4'hF, er);
        axi_read(32'h40, rd, rr);
        check("rst_committed_word", rd, 32'h5A5A0001);
        axi_read(32'h10, rd, rr);
        check("rst_retained_word", rd, 32'hDEADBEEF);

        // randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), br);
                model_write(a, d, s, er);
                check("rand_bresp", br, er);
            end else begin
                model_read(a, ed, er, kn);
                axi_read(a, rd, rr);
                check("rand_rresp", rr, er);
                if (kn) check("rand_rdata", rd, ed);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard stop in case a handshake loop is ever bypassed
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
